// File: rtl/noc_ni_pkg.sv
// Shared types and packet helpers for the mesh resource network interface.
// Packet layout, MSB to LSB: {data, row, col}.
package noc_ni_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    localparam int PCKT_MAX_W = 64;

    function automatic logic [PCKT_MAX_W-1:0] pckt_pack(
        input logic [31:0] data,
        input logic [15:0] row,
        input logic [15:0] col,
        input int          row_w,
        input int          col_w
    );
        return (64'(data) << (row_w + col_w))
             | (64'(row) << col_w)
             | 64'(col);
    endfunction

    function automatic logic [31:0] pckt_data(
        input logic [PCKT_MAX_W-1:0] pckt,
        input int                    row_w,
        input int                    col_w
    );
        return 32'(pckt >> (row_w + col_w));
    endfunction

    function automatic logic [15:0] pckt_row(
        input logic [PCKT_MAX_W-1:0] pckt,
        input int                    row_w,
        input int                    col_w
    );
        return 16'((pckt >> col_w) & ((64'd1 << row_w) - 64'd1));
    endfunction

    function automatic logic [15:0] pckt_col(
        input logic [PCKT_MAX_W-1:0] pckt,
        input int                    col_w
    );
        return 16'(pckt & ((64'd1 << col_w) - 64'd1));
    endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// First-word-fall-through receive FIFO; a push that finds it full
// (and no pop in the same cycle) is dropped and flagged one cycle later.
module ni_rx_fifo #(
    parameter int W       = 8,
    parameter int DEPTH_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic         full,
    output logic         push_ok,
    output logic         push_drop,
    output logic         ovrflw
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [W-1:0]       mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W:0]   count;
    logic               pop_ok;

    assign valid     = (count != '0);
    assign full      = (count == (DEPTH_W+1)'(DEPTH));
    assign pop_ok    = pop & valid;
    assign push_ok   = push & (~full | pop_ok);
    assign push_drop = push & ~push_ok;
    assign rdata     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovrflw <= 1'b0;
        end else begin
            ovrflw <= push_drop;
            if (push_ok) wr_ptr <= wr_ptr + DEPTH_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (DEPTH_W+1)'(1);
                2'b01:   count <= count - (DEPTH_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/noc_rsc_ni.sv
// Resource network interface for mesh switch port 0 (TX inject, RX buffer).
// Optional statistics counters are built when NI_PKT_STATS_EN is defined.
module noc_rsc_ni
    import noc_ni_pkg::*;
#(
    parameter int ROW_N        = 3,
    parameter int COL_M        = 3,
    parameter int ROW_CORD     = 0,
    parameter int COL_CORD     = 0,
    parameter int PCKT_DATA_W  = 8,
    parameter int FIFO_DEPTH_W = 3,
    parameter int STAT_W       = 16,
    localparam int ROW_ADDR_W  = $clog2(ROW_N),
    localparam int COL_ADDR_W  = $clog2(COL_M),
    localparam int PCKT_W      = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    input  logic [ROW_ADDR_W-1:0]  tx_row_i,
    input  logic [COL_ADDR_W-1:0]  tx_col_i,
    input  logic [PCKT_DATA_W-1:0] tx_data_i,
    output logic                   tx_err_o,
    output logic [PCKT_W-1:0]      ni_pckt_o,
    output logic                   ni_wren_o,
    input  logic                   noc_full_i,
    input  logic                   noc_ovrflw_i,
    output logic                   tx_ovrflw_o,
    input  logic [PCKT_W-1:0]      noc_pckt_i,
    input  logic                   noc_wren_i,
    output logic                   ni_full_o,
    output logic                   ni_ovrflw_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic [ROW_ADDR_W-1:0]  rx_row_o,
    output logic [COL_ADDR_W-1:0]  rx_col_o,
    output logic [PCKT_DATA_W-1:0] rx_data_o,
    output logic [STAT_W-1:0]      stat_tx_cnt_o,
    output logic [STAT_W-1:0]      stat_rx_cnt_o,
    output logic [STAT_W-1:0]      stat_drop_cnt_o
);

    tx_state_t         state;
    logic [PCKT_W-1:0] hold;
    logic [PCKT_W-1:0] pckt;
    logic [PCKT_W-1:0] head;
    logic [PCKT_W-1:0] rdata;
    logic              dst_ok;
    logic              accept;
    logic              push_ok;
    logic              push_drop;

    // The own node is always a legal target and is sent like any other.
    assign dst_ok = (32'(tx_row_i) < ROW_N && 32'(tx_col_i) < COL_M)
                  || (32'(tx_row_i) == ROW_CORD && 32'(tx_col_i) == COL_CORD);

    assign pckt = PCKT_W'(pckt_pack(32'(tx_data_i), 16'(tx_row_i),
                                    16'(tx_col_i), ROW_ADDR_W, COL_ADDR_W));

    assign ni_wren_o  = (state == TX_SEND) & ~noc_full_i;
    assign ni_pckt_o  = hold;
    assign tx_ready_o = (state == TX_IDLE) | ~noc_full_i;
    assign accept     = tx_valid_i & tx_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= TX_IDLE;
            hold        <= '0;
            tx_err_o    <= 1'b0;
            tx_ovrflw_o <= 1'b0;
        end else begin
            tx_err_o <= accept & ~dst_ok;
            if (noc_ovrflw_i) tx_ovrflw_o <= 1'b1;
            unique case (state)
                TX_IDLE: begin
                    if (accept && dst_ok) begin
                        hold  <= pckt;
                        state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (ni_wren_o) begin
                        if (accept && dst_ok) hold <= pckt;
                        else                  state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    ni_rx_fifo #(
        .W       (PCKT_W),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_rx_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (noc_wren_i),
        .wdata     (noc_pckt_i),
        .pop       (rx_ready_i),
        .rdata     (rdata),
        .valid     (rx_valid_o),
        .full      (ni_full_o),
        .push_ok   (push_ok),
        .push_drop (push_drop),
        .ovrflw    (ni_ovrflw_o)
    );

    // Mask unwritten storage so an empty FIFO presents zeros.
    assign head      = rx_valid_o ? rdata : '0;
    assign rx_data_o = PCKT_DATA_W'(pckt_data(64'(head), ROW_ADDR_W, COL_ADDR_W));
    assign rx_row_o  = ROW_ADDR_W'(pckt_row(64'(head), ROW_ADDR_W, COL_ADDR_W));
    assign rx_col_o  = COL_ADDR_W'(pckt_col(64'(head), COL_ADDR_W));

`ifdef NI_PKT_STATS_EN
    logic [STAT_W-1:0] tx_cnt;
    logic [STAT_W-1:0] rx_cnt;
    logic [STAT_W-1:0] drop_cnt;
    logic [1:0]        drop_inc;

    function automatic logic [STAT_W-1:0] sat_add(
        input logic [STAT_W-1:0] a,
        input logic [1:0]        inc
    );
        logic [STAT_W:0] s;
        s = {1'b0, a} + (STAT_W+1)'(inc);
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

    assign drop_inc = {1'b0, push_drop} + {1'b0, accept & ~dst_ok};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            tx_cnt   <= sat_add(tx_cnt, {1'b0, ni_wren_o});
            rx_cnt   <= sat_add(rx_cnt, {1'b0, push_ok});
            drop_cnt <= sat_add(drop_cnt, drop_inc);
        end
    end

    assign stat_tx_cnt_o   = tx_cnt;
    assign stat_rx_cnt_o   = rx_cnt;
    assign stat_drop_cnt_o = drop_cnt;
`else
    logic stat_unused;
    assign stat_unused     = push_ok ^ push_drop;
    assign stat_tx_cnt_o   = '0;
    assign stat_rx_cnt_o   = '0;
    assign stat_drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_rsc_ni.sv
// Scoreboard bench for noc_rsc_ni (3x3 mesh, node 0,0, 8-deep RX FIFO).
// Statistic expectations follow NI_PKT_STATS_EN when it is defined.
module tb_noc_rsc_ni;

    localparam int RW = 2;
    localparam int CW = 2;
    localparam int DW = 8;
    localparam int PW = DW + RW + CW;
    localparam int SW = 16;
`ifdef NI_PKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o;
    logic [RW-1:0] tx_row_i = '0;
    logic [CW-1:0] tx_col_i = '0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_err_o;
    logic [PW-1:0] ni_pckt_o;
    logic          ni_wren_o;
    logic          noc_full_i = 1'b0;
    logic          noc_ovrflw_i = 1'b0;
    logic          tx_ovrflw_o;
    logic [PW-1:0] noc_pckt_i = '0;
    logic          noc_wren_i = 1'b0;
    logic          ni_full_o;
    logic          ni_ovrflw_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b0;
    logic [RW-1:0] rx_row_o;
    logic [CW-1:0] rx_col_o;
    logic [DW-1:0] rx_data_o;
    logic [SW-1:0] stat_tx_cnt_o;
    logic [SW-1:0] stat_rx_cnt_o;
    logic [SW-1:0] stat_drop_cnt_o;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            tx_wr = 0;
    int            rx_rd = 0;
    int            tx_sent = 0;
    int            cyc = 0;
    int            start;
    logic [PW-1:0] tx_q[$];
    logic [PW-1:0] rx_q[$];
    logic [PW-1:0] p;

    always #5 clk = ~clk;

    noc_rsc_ni #(
        .ROW_N        (3),
        .COL_M        (3),
        .ROW_CORD     (0),
        .COL_CORD     (0),
        .PCKT_DATA_W  (DW),
        .FIFO_DEPTH_W (3),
        .STAT_W       (SW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_row_i        (tx_row_i),
        .tx_col_i        (tx_col_i),
        .tx_data_i       (tx_data_i),
        .tx_err_o        (tx_err_o),
        .ni_pckt_o       (ni_pckt_o),
        .ni_wren_o       (ni_wren_o),
        .noc_full_i      (noc_full_i),
        .noc_ovrflw_i    (noc_ovrflw_i),
        .tx_ovrflw_o     (tx_ovrflw_o),
        .noc_pckt_i      (noc_pckt_i),
        .noc_wren_i      (noc_wren_i),
        .ni_full_o       (ni_full_o),
        .ni_ovrflw_o     (ni_ovrflw_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .rx_row_o        (rx_row_o),
        .rx_col_o        (rx_col_o),
        .rx_data_o       (rx_data_o),
        .stat_tx_cnt_o   (stat_tx_cnt_o),
        .stat_rx_cnt_o   (stat_rx_cnt_o),
        .stat_drop_cnt_o (stat_drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int d, input int r, input int c);
        return {DW'(d), RW'(r), CW'(c)};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int c, input int d);
        int budget;
        budget     = 50;
        tx_row_i   = RW'(r);
        tx_col_i   = CW'(c);
        tx_data_i  = DW'(d);
        tx_valid_i = 1'b1;
        @(negedge clk);
        while (!tx_ready_o && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (!tx_ready_o) chk("tx_timeout", 64'(tx_ready_o), 64'(1));
        else if (r < 3 && c < 3) begin
            tx_q.push_back(mk(d, r, c));
            tx_sent++;
        end
        @(posedge clk);
        #1;
        tx_valid_i = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (ni_wren_o) begin
                tx_wr++;
                if (tx_q.size() == 0) chk("tx_extra", 64'(ni_wren_o), 64'(0));
                else chk("tx_pckt", 64'(ni_pckt_o), 64'(tx_q.pop_front()));
            end
            if (rx_valid_o && rx_ready_i) begin
                rx_rd++;
                if (rx_q.size() == 0) chk("rx_extra", 64'(rx_valid_o), 64'(0));
                else chk("rx_pckt", 64'({rx_data_o, rx_row_o, rx_col_o}),
                         64'(rx_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_wren", 64'(ni_wren_o), 64'(0));
        chk("rst_pckt", 64'(ni_pckt_o), 64'(0));
        chk("rst_err", 64'(tx_err_o), 64'(0));
        chk("rst_txovf", 64'(tx_ovrflw_o), 64'(0));
        chk("rst_ready", 64'(tx_ready_o), 64'(1));
        chk("rst_rxvalid", 64'(rx_valid_o), 64'(0));
        chk("rst_full", 64'(ni_full_o), 64'(0));
        chk("rst_rxovf", 64'(ni_ovrflw_o), 64'(0));
        chk("rst_rxdata", 64'({rx_data_o, rx_row_o, rx_col_o}), 64'(0));
        chk("rst_stats", 64'({stat_tx_cnt_o, stat_rx_cnt_o, stat_drop_cnt_o}), 64'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        send(2, 1, 'hA5);
        @(negedge clk);
        chk("tx_lat", 64'(ni_wren_o), 64'(1));
        chk("tx_a5", 64'(ni_pckt_o), 64'(12'hA59));
        cycles(3);
        chk("tx_once", 64'(tx_wr), 64'(1));

        send(1, 2, 'h3C);
        noc_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_wren", 64'(ni_wren_o), 64'(0));
            chk("full_ready", 64'(tx_ready_o), 64'(0));
        end
        chk("full_hold", 64'(ni_pckt_o), 64'(mk('h3C, 1, 2)));
        @(posedge clk);
        #1;
        noc_full_i = 1'b0;
        cycles(3);
        chk("full_once", 64'(tx_wr), 64'(2));

        start = cyc;
        send(0, 0, 'h11);
        send(1, 1, 'h22);
        send(2, 2, 'h33);
        send(0, 2, 'h44);
        chk("b2b_cyc", 64'(cyc - start), 64'(4));
        cycles(3);
        chk("b2b_wr", 64'(tx_wr), 64'(tx_sent));

        send(3, 1, 'h5A);
        chk("err_pulse", 64'(tx_err_o), 64'(1));
        cycles(1);
        chk("err_clr", 64'(tx_err_o), 64'(0));
        cycles(2);
        chk("err_nowr", 64'(tx_wr), 64'(6));
        chk("st_drop1", 64'(stat_drop_cnt_o), STATS ? 64'(1) : 64'(0));
        chk("st_tx", 64'(stat_tx_cnt_o), STATS ? 64'(6) : 64'(0));

        rx_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            p = mk('h10 + i, i % 3, (i + 1) % 3);
            noc_pckt_i = p;
            noc_wren_i = 1'b1;
            if (i < 8) rx_q.push_back(p);
            @(posedge clk);
            #1;
            if (i == 6) chk("rx_not_full", 64'(ni_full_o), 64'(0));
            if (i == 7) chk("rx_full8", 64'(ni_full_o), 64'(1));
            if (i == 7) chk("rx_no_ovf", 64'(ni_ovrflw_o), 64'(0));
            if (i == 8) chk("rx_ovf", 64'(ni_ovrflw_o), 64'(1));
        end
        noc_wren_i = 1'b0;
        cycles(1);
        chk("rx_ovf_clr", 64'(ni_ovrflw_o), 64'(0));
        chk("rx_valid", 64'(rx_valid_o), 64'(1));

        p = mk('h77, 1, 0);
        noc_pckt_i = p;
        noc_wren_i = 1'b1;
        rx_ready_i = 1'b1;
        rx_q.push_back(p);
        @(posedge clk);
        #1;
        noc_wren_i = 1'b0;
        rx_ready_i = 1'b0;
        chk("pp_full", 64'(ni_full_o), 64'(1));
        chk("pp_ovf", 64'(ni_ovrflw_o), 64'(0));

        rx_ready_i = 1'b1;
        for (int k = 0; k < 40 && rx_valid_o; k++) cycles(1);
        rx_ready_i = 1'b0;
        chk("drain_valid", 64'(rx_valid_o), 64'(0));
        chk("drain_full", 64'(ni_full_o), 64'(0));
        chk("drain_cnt", 64'(rx_rd), 64'(9));
        chk("drain_q", 64'(rx_q.size()), 64'(0));
        chk("st_rx", 64'(stat_rx_cnt_o), STATS ? 64'(9) : 64'(0));
        chk("st_drop2", 64'(stat_drop_cnt_o), STATS ? 64'(2) : 64'(0));

        noc_pckt_i = mk('h99, 2, 2);
        noc_wren_i = 1'b1;
        cycles(1);
        noc_wren_i = 1'b0;
        noc_full_i = 1'b1;
        send(1, 1, 'h66);
        noc_ovrflw_i = 1'b1;
        cycles(1);
        noc_ovrflw_i = 1'b0;
        chk("txovf_set", 64'(tx_ovrflw_o), 64'(1));
        cycles(3);
        chk("txovf_hold", 64'(tx_ovrflw_o), 64'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_txovf", 64'(tx_ovrflw_o), 64'(0));
        chk("arst_rxvalid", 64'(rx_valid_o), 64'(0));
        chk("arst_pckt", 64'(ni_pckt_o), 64'(0));
        chk("arst_stat", 64'(stat_tx_cnt_o), 64'(0));
        tx_q.delete();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        noc_full_i = 1'b0;
        @(negedge clk);
        chk("post_rst_wren", 64'(ni_wren_o), 64'(0));
        cycles(3);
        chk("post_rst_q", 64'(tx_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_rsc_ni.md
# noc_rsc_ni

Resource network interface between one processing resource and its local node of the 2D mesh XY NoC. TX side builds single-flit packets `{data, row, col}` from a valid/ready request and injects them into the node's resource input channel, respecting the node's full flag. RX side buffers packets ejected by the node in a local FIFO, drives full/overflow back to the node, and presents them to the resource over valid/ready. One instance sits on port 0 of each mesh switch.

## Interface
- `ROW_N`, 3: mesh rows, ≥2
- `COL_M`, 3: mesh columns, ≥2
- `ROW_CORD`, 0: this node's row
- `COL_CORD`, 0: this node's column
- `PCKT_DATA_W`, 8: payload width
- `FIFO_DEPTH_W`, 3: RX FIFO depth = 2^FIFO_DEPTH_W
- `STAT_W`, 16: statistics counter width
- Derived: `ROW_ADDR_W=$clog2(ROW_N)`, `COL_ADDR_W=$clog2(COL_M)`, `PCKT_W=PCKT_DATA_W+ROW_ADDR_W+COL_ADDR_W`

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `tx_valid_i` in 1 / `tx_ready_o` out 1: resource request handshake
- `tx_row_i` in ROW_ADDR_W, `tx_col_i` in COL_ADDR_W, `tx_data_i` in PCKT_DATA_W: destination and payload
- `tx_err_o` out 1: one-cycle pulse, out-of-range destination dropped
- `ni_pckt_o` out PCKT_W, `ni_wren_o` out 1: to node rsc_pckt/rsc_wren
- `noc_full_i` in 1, `noc_ovrflw_i` in 1: node input FIFO status
- `tx_ovrflw_o` out 1: sticky, node reported overflow
- `noc_pckt_i` in PCKT_W, `noc_wren_i` in 1: from node packet output
- `ni_full_o` out 1, `ni_ovrflw_o` out 1: to node rsc_full/rsc_ovrflw
- `rx_valid_o` out 1 / `rx_ready_i` in 1: delivery handshake
- `rx_row_o`, `rx_col_o`, `rx_data_o` out: unpacked head packet
- `stat_tx_cnt_o`, `stat_rx_cnt_o`, `stat_drop_cnt_o` out STAT_W each

## Operation
- Packet layout: data in `[PCKT_W-1 -: PCKT_DATA_W]`, row next, col in LSBs.
- TX FSM, states `TX_IDLE`, `TX_SEND`, plus a hold register (packet).
  - `TX_IDLE`: `tx_ready_o=1`. Accept on `tx_valid_i`. Valid destination (row<ROW_N, col<COL_M): load hold, go `TX_SEND`. Invalid: drop, `tx_err_o` pulses next cycle, stay `TX_IDLE`.
  - `TX_SEND`: `ni_wren_o = ~noc_full_i` (combinational), `ni_pckt_o` = hold. `tx_ready_o = ~noc_full_i`. On write with new valid accept: reload hold, stay. On write without accept, or accept of invalid destination: go `TX_IDLE` (error pulse as above). Full: hold and wait indefinitely.
- Destination equal to own coordinates is sent normally.
- `noc_ovrflw_i` high any cycle sets `tx_ovrflw_o` until reset.
- RX: FIFO, first-word-fall-through, `rx_valid_o = count!=0`. Write accepted when `noc_wren_i` and (count<depth or pop same cycle). Otherwise the packet is dropped and `ni_ovrflw_o` pulses one cycle later. `ni_full_o = (count==depth)`. Pop on `rx_valid_o & rx_ready_i`. Simultaneous push/pop keeps count. Pointers wrap modulo depth; count is FIFO_DEPTH_W+1 bits.

## Timing
- Reset: state `TX_IDLE`, hold 0, `ni_wren_o=0`, `ni_pckt_o=0`, `tx_err_o=0`, `tx_ovrflw_o=0`, FIFO empty, `rx_valid_o=0`, `ni_full_o=0`, `ni_ovrflw_o=0`, stats 0, RX outputs 0.
- TX latency: accepted at edge N, `ni_wren_o` earliest in cycle N+1. Back-to-back sustains 1 packet/cycle while `noc_full_i=0`.
- RX latency: written at edge N, `rx_valid_o` in cycle N+1.
- Reset mid-operation discards hold register and FIFO contents; no write issued in reset.

## Configuration
- `NI_PKT_STATS_EN` defined: `stat_tx_cnt_o` counts `ni_wren_o` cycles, `stat_rx_cnt_o` counts accepted RX writes, `stat_drop_cnt_o` counts RX drops plus TX invalid-destination drops. All saturate at all-ones.
- Undefined: counters not built, stat ports tied to 0. Interface unchanged.

## Structure
- Package `noc_ni_pkg`: packet field offsets/widths, pack/unpack functions, TX state encoding.
- Sub-module `ni_rx_fifo`: synchronous FWFT FIFO with count, full, push-while-full drop flag.

## Test plan
- Reset, `tx_valid_i=1` row=2 col=1 data=0xA5, `noc_full_i=0` -> `ni_wren_o=1` next cycle, `ni_pckt_o`={0xA5,2,1}, exactly one write.
- `noc_full_i=1` for 5 cycles during `TX_SEND` -> `ni_wren_o=0`, `tx_ready_o=0`, packet held. Release full -> single write, same packet.
- 3x3 mesh, row=3 -> `tx_err_o` one pulse, no `ni_wren_o`, `stat_drop_cnt_o=1` with macro.
- Depth 8, `rx_ready_i=0`, 9 `noc_wren_i` writes -> `ni_full_o` after 8th, 9th dropped with `ni_ovrflw_o` pulse. Drain yields 8 packets in order.
- FIFO full, `noc_wren_i` and pop same cycle -> write accepted, count stays 8, no overflow.
- `noc_ovrflw_i` one-cycle pulse -> `tx_ovrflw_o` stays 1 until `rst_ni` low, cleared asynchronously.
